// File: rtl/axis_burst_gate.sv
// axis_burst_gate: releases FIFO contents to an AXI4-Stream sink only in whole
// bursts of cfg_data words, starting a burst only once the FIFO already holds
// the full burst, and marking the final beat of each burst with m_axis_tlast.
// cfg_data is zero-extended to 32 bits for the fill comparison (CNTR_WIDTH <= 32).
module axis_burst_gate #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [CNTR_WIDTH-1:0]       cfg_data,
  input  logic                        cfg_enable,
  input  logic [31:0]                 fifo_count,
  output logic [31:0]                 sts_bursts,
  output logic                        busy,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast
);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CNTR_WIDTH-1:0] len;
  logic [CNTR_WIDTH-1:0] cnt;
  logic                  start;
  logic                  s_hs;
  logic                  m_hs;
  logic                  last_beat;

  assign start     = cfg_enable && (cfg_data != '0) && (fifo_count >= 32'(cfg_data));
  assign s_hs      = s_axis_tvalid && s_axis_tready;
  assign m_hs      = m_axis_tvalid && m_axis_tready;
  assign last_beat = (cnt == len - CNTR_WIDTH'(1));

  // State register: reset always returns to IDLE, abandoning any partial burst.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: start only on a full FIFO, leave BURST on the last accepted word.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BURST;
      BURST:   if (s_hs && last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: accept words only in BURST when the output stage can take one.
  always_comb begin
    s_axis_tready = 1'b0;
    if (state == BURST) begin
      s_axis_tready = !m_axis_tvalid || m_axis_tready;
    end
    busy = (state == BURST) || m_axis_tvalid;
  end

  // Burst length latch and beat counter; len is frozen for the whole burst.
  always_ff @(posedge aclk) begin
    if (areset) begin
      len <= '0;
      cnt <= '0;
    end else if (state == IDLE && start) begin
      len <= cfg_data;
      cnt <= '0;
    end else if (s_hs) begin
      cnt <= cnt + CNTR_WIDTH'(1);
    end
  end

  // One-stage output register: reload on every accepted word, empty on drain.
  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (s_hs) begin
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= last_beat;
    end else if (m_hs) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end
  end

  // Completed-burst counter, bumped when the sink takes a tlast beat.
  always_ff @(posedge aclk) begin
    if (areset) begin
      sts_bursts <= '0;
    end else if (m_hs && m_axis_tlast) begin
      sts_bursts <= sts_bursts + 32'd1;
    end
  end

endmodule

// File: tb/tb_axis_burst_gate.sv
// Testbench for axis_burst_gate: a queue models the FIFO feeding the gate,
// and a scoreboard holds the expected beat (data and tlast) for every accepted word.
module tb_axis_burst_gate;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          aclk = 1'b0;
  logic          areset;
  logic [CW-1:0] cfg_data;
  logic          cfg_enable;
  logic [31:0]   fifo_count;
  logic [31:0]   sts_bursts;
  logic          busy;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;

  axis_burst_gate #(
    .AXIS_TDATA_WIDTH(DW),
    .CNTR_WIDTH      (CW)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .cfg_data     (cfg_data),
    .cfg_enable   (cfg_enable),
    .fifo_count   (fifo_count),
    .sts_bursts   (sts_bursts),
    .busy         (busy),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast)
  );

  // Free-running 10 ns clock.
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         sb_q[$];
  logic [DW-1:0] src_q[$];

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            m_beats = 0;
  int            exp_len_next = 1;
  int            exp_len_cur = 1;
  int            beat_idx = 0;
  int            count_override = -1;
  int            first_m_cyc = 0;
  int            last_m_cyc = 0;
  logic [31:0]   exp_bursts = 0;
  bit            src_en = 1'b0;
  bit            ready_toggle = 1'b0;
  bit            ready_const = 1'b1;
  bit            gap_pending = 1'b0;
  bit            held_valid = 1'b0;
  bit            held_last = 1'b0;
  bit            track_first = 1'b0;
  logic [DW-1:0] held_data = '0;
  logic [3:0]    ready_pattern = 4'b1001;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive the FIFO model and sink, check the m side, update the scoreboard.
  task automatic stepCycle();
    beat_t exp_b;
    logic  s_hs;
    logic  m_hs;
    s_axis_tvalid = src_en && (src_q.size() > 0);
    s_axis_tdata  = (src_q.size() > 0) ? src_q[0] : '0;
    fifo_count    = (count_override >= 0) ? 32'(count_override) : 32'(src_q.size());
    m_axis_tready = ready_toggle ? ready_pattern[cyc % 4] : ready_const;
    #4;
    s_hs = s_axis_tvalid && s_axis_tready;
    m_hs = m_axis_tvalid && m_axis_tready;
    if (gap_pending) begin
      checkOutput("gap_tready", 64'(s_axis_tready), 64'd0);
      gap_pending = 1'b0;
    end
    if (held_valid) begin
      checkOutput("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
      checkOutput("hold_tdata", 64'(m_axis_tdata), 64'(held_data));
      checkOutput("hold_tlast", 64'(m_axis_tlast), 64'(held_last));
      held_valid = 1'b0;
    end
    if (m_axis_tvalid && !m_axis_tready) begin
      held_valid = 1'b1;
      held_data  = m_axis_tdata;
      held_last  = m_axis_tlast;
    end
    if (m_hs) begin
      checkOutput("beat_expected", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        exp_b = sb_q.pop_front();
        checkOutput("m_tdata", 64'(m_axis_tdata), 64'(exp_b.data));
        checkOutput("m_tlast", 64'(m_axis_tlast), 64'(exp_b.last));
        if (exp_b.last) exp_bursts++;
      end
      if (track_first) begin
        first_m_cyc = cyc;
        track_first = 1'b0;
      end
      last_m_cyc = cyc;
      m_beats++;
    end
    if (s_hs) begin
      if (beat_idx == 0) exp_len_cur = exp_len_next;
      exp_b.data = s_axis_tdata;
      exp_b.last = (beat_idx == exp_len_cur - 1);
      sb_q.push_back(exp_b);
      if (exp_b.last) begin
        beat_idx    = 0;
        gap_pending = 1'b1;
      end else begin
        beat_idx++;
      end
    end
    @(posedge aclk);
    #1;
    if (s_hs) void'(src_q.pop_front());
    cyc++;
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic runUntilBeats(input string tag, input int n, input int budget);
    int target;
    int used;
    target = m_beats + n;
    used   = 0;
    while (m_beats < target && used < budget) begin
      stepCycle();
      used++;
    end
    checkOutput(tag, 64'(m_beats >= target), 64'd1);
  endtask

  task automatic pushWords(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) src_q.push_back(base + DW'(i));
  endtask

  // Directed sequence covering start gating, chaining, config freeze, backpressure and reset.
  initial begin
    int beats_before;
    areset        = 1'b1;
    cfg_data      = '0;
    cfg_enable    = 1'b0;
    fifo_count    = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    checkOutput("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("rst_tdata", 64'(m_axis_tdata), 64'd0);
    checkOutput("rst_tlast", 64'(m_axis_tlast), 64'd0);
    checkOutput("rst_sts", 64'(sts_bursts), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_tready", 64'(s_axis_tready), 64'd0);
    areset = 1'b0;

    $display("[TB] test 1: start waits for a full burst in the FIFO");
    cfg_data     = 16'd4;
    cfg_enable   = 1'b1;
    exp_len_next = 4;
    src_en       = 1'b1;
    ready_const  = 1'b1;
    pushWords(32'h0000_0100, 3);
    applyStimulus(6);
    checkOutput("t1_tready_short", 64'(s_axis_tready), 64'd0);
    checkOutput("t1_no_beats", 64'(m_beats), 64'd0);
    checkOutput("t1_src_left", 64'(src_q.size()), 64'd3);
    checkOutput("t1_busy_idle", 64'(busy), 64'd0);
    pushWords(32'h0000_0103, 1);
    track_first = 1'b1;
    runUntilBeats("t1_beats", 4, 20);
    checkOutput("t1_back_to_back", 64'(last_m_cyc - first_m_cyc), 64'd3);
    applyStimulus(2);
    checkOutput("t1_sts", 64'(sts_bursts), 64'd1);
    checkOutput("t1_sts_model", 64'(sts_bursts), 64'(exp_bursts));
    checkOutput("t1_busy_done", 64'(busy), 64'd0);

    $display("[TB] test 2: two chained bursts of 8 from 20 words");
    cfg_data     = 16'd8;
    exp_len_next = 8;
    pushWords(32'h0000_0200, 20);
    runUntilBeats("t2_beats", 16, 60);
    applyStimulus(4);
    checkOutput("t2_sts", 64'(sts_bursts), 64'd3);
    checkOutput("t2_src_left", 64'(src_q.size()), 64'd4);
    checkOutput("t2_tready_idle", 64'(s_axis_tready), 64'd0);

    $display("[TB] test 3: config changes mid-burst are ignored");
    pushWords(32'h0000_0300, 12);
    runUntilBeats("t3_first3", 3, 20);
    cfg_data     = 16'd2;
    cfg_enable   = 1'b0;
    exp_len_next = 2;
    runUntilBeats("t3_rest", 5, 20);
    applyStimulus(6);
    checkOutput("t3_src_left", 64'(src_q.size()), 64'd8);
    checkOutput("t3_tready_dis", 64'(s_axis_tready), 64'd0);
    checkOutput("t3_busy_dis", 64'(busy), 64'd0);
    checkOutput("t3_sts_long", 64'(sts_bursts), 64'd4);
    cfg_enable = 1'b1;
    runUntilBeats("t3_short", 8, 60);
    applyStimulus(2);
    checkOutput("t3_sts_short", 64'(sts_bursts), 64'd8);
    checkOutput("t3_src_empty", 64'(src_q.size()), 64'd0);

    $display("[TB] test 4: sink backpressure 1,0,0,1 over a 5-word burst");
    cfg_data     = 16'd5;
    exp_len_next = 5;
    ready_toggle = 1'b1;
    pushWords(32'h0000_0400, 5);
    runUntilBeats("t4_beats", 5, 40);
    ready_toggle = 1'b0;
    applyStimulus(2);
    checkOutput("t4_sts", 64'(sts_bursts), 64'd9);
    checkOutput("t4_busy", 64'(busy), 64'd0);

    $display("[TB] test 5: reset after beat 3 of a 6-word burst");
    cfg_data     = 16'd6;
    exp_len_next = 6;
    pushWords(32'h0000_0500, 6);
    runUntilBeats("t5_three", 3, 20);
    cfg_enable    = 1'b0;
    src_en        = 1'b0;
    s_axis_tvalid = 1'b0;
    areset        = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    sb_q.delete();
    src_q.delete();
    beat_idx    = 0;
    gap_pending = 1'b0;
    held_valid  = 1'b0;
    exp_bursts  = '0;
    checkOutput("t5_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("t5_tlast", 64'(m_axis_tlast), 64'd0);
    checkOutput("t5_sts", 64'(sts_bursts), 64'd0);
    checkOutput("t5_busy", 64'(busy), 64'd0);
    checkOutput("t5_tready", 64'(s_axis_tready), 64'd0);
    beats_before = m_beats;
    applyStimulus(4);
    checkOutput("t5_no_more_beats", 64'(m_beats - beats_before), 64'd0);
    checkOutput("t5_tvalid_later", 64'(m_axis_tvalid), 64'd0);

    $display("[TB] test 6: zero burst length never starts");
    cfg_data       = 16'd0;
    cfg_enable     = 1'b1;
    src_en         = 1'b1;
    count_override = 100;
    pushWords(32'h0000_0600, 3);
    beats_before = m_beats;
    applyStimulus(8);
    checkOutput("t6_tready", 64'(s_axis_tready), 64'd0);
    checkOutput("t6_busy", 64'(busy), 64'd0);
    checkOutput("t6_src_left", 64'(src_q.size()), 64'd3);
    checkOutput("t6_no_beats", 64'(m_beats - beats_before), 64'd0);
    checkOutput("t6_sts", 64'(sts_bursts), 64'(exp_bursts));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
